// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory-access stage: control-bus bit
// indices, access size codes, FSM state encoding and byte-enable constants.
package mips_mem_pkg;

  // WB control bus bit positions
  localparam int WB_REG_WRITE  = 0;
  localparam int WB_MEM_TO_REG = 1;

  // MEM control bus bit positions
  localparam int MEM_READ      = 0;
  localparam int MEM_WRITE     = 1;
  localparam int MEM_SIZE_LSB  = 2;
  localparam int MEM_UNSIGNED  = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  // Byte enables for a store of the given size at the given byte offset.
  // Size code 2'b11 is undefined and is treated as a word.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: store_be = BE_BYTE0 << off;
      SIZE_HALF: store_be = off[1] ? BE_HI_HALF : BE_LO_HALF;
      default:   store_be = BE_ALL;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/half out of the returned
// word and sign- or zero-extends it to the datapath width.
module mem_load_align
  import mips_mem_pkg::*;
#(
  parameter int NB_BITS = 32
) (
  input  logic [NB_BITS-1:0] i_rdata,
  input  logic [1:0]         i_off,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  output logic [NB_BITS-1:0] o_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection then extension; the word case passes the memory word through.
  always_comb begin
    byte_sel = 8'h00;
    case (i_off)
      2'd0: byte_sel = i_rdata[7:0];
      2'd1: byte_sel = i_rdata[15:8];
      2'd2: byte_sel = i_rdata[23:16];
      2'd3: byte_sel = i_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SIZE_BYTE: o_data = {{(NB_BITS-8){~i_unsigned & byte_sel[7]}}, byte_sel};
      SIZE_HALF: o_data = {{(NB_BITS-16){~i_unsigned & half_sel[15]}}, half_sel};
      default:   o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: EX/MEM register, data-memory req/ack handshake
// with byte-lane steering, load extension and the MEM/WB register.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned half/word accesses
// are suppressed and flagged instead of issued).
//
// Handshake: o_dmem_req is raised combinationally whenever the EX/MEM
// register holds a memory op; the request and all o_dmem_* fields stay
// stable until the cycle i_dmem_ack is seen high, and the access completes
// on the rising edge that ends that cycle. Ack without a request is ignored.
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int NB_BITS = 32,
  parameter int NB_REG  = 5,
  parameter int NB_CTL  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [NB_BITS-1:0] i_alu_out,
  input  logic [NB_BITS-1:0] i_data_reg,
  input  logic [NB_REG-1:0]  i_reg_dst,
  input  logic [NB_CTL-1:0]  i_wb_ctl,
  input  logic [NB_CTL-1:0]  i_mem_ctl,
  output logic               o_stall,
  output logic [NB_BITS-1:0] o_ex_mem_reg_hz,
  output logic [NB_REG-1:0]  o_ex_mem_reg_dst,
  output logic               o_ex_mem_reg_write,
  output logic               o_dmem_req,
  output logic               o_dmem_we,
  output logic [NB_BITS-1:0] o_dmem_addr,
  output logic [NB_BITS-1:0] o_dmem_wdata,
  output logic [3:0]         o_dmem_be,
  input  logic               i_dmem_ack,
  input  logic [NB_BITS-1:0] i_dmem_rdata,
  output logic               o_valid,
  output logic [NB_BITS-1:0] o_alu_out,
  output logic [NB_BITS-1:0] o_mem_data,
  output logic [NB_REG-1:0]  o_reg_dst,
  output logic [NB_CTL-1:0]  o_wb_ctl,
  output logic               o_misaligned
);

  // EX/MEM pipeline register
  logic               ex_valid_q;
  logic [NB_BITS-1:0] ex_alu_q;
  logic [NB_BITS-1:0] ex_rt_q;
  logic [NB_REG-1:0]  ex_dst_q;
  logic [NB_CTL-1:0]  ex_wb_q;
  logic [NB_CTL-1:0]  ex_mem_q;

  state_e state_q, state_d;

  logic               mem_read, mem_write, is_load, misaligned, mem_op;
  logic [1:0]         off, size;
  logic [NB_BITS-1:0] load_data;
  logic [NB_CTL-1:0]  wb_fwd;
  logic               unused_mem_ctl;

  assign mem_read  = ex_mem_q[MEM_READ];
  assign mem_write = ex_mem_q[MEM_WRITE];
  assign size      = ex_mem_q[MEM_SIZE_LSB +: 2];
  assign off       = ex_alu_q[1:0];
  assign is_load   = mem_read & ~mem_write;  // write wins when both are set
  assign unused_mem_ctl = ^ex_mem_q[NB_CTL-1:MEM_UNSIGNED+1];

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ex_valid_q & (mem_read | mem_write) &
                      (((size == SIZE_HALF) & off[0]) | (size[1] & (off != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign mem_op  = ex_valid_q & (mem_read | mem_write) & ~misaligned;
  assign o_stall = mem_op & ~i_dmem_ack;

  // Forwarding taps come straight from EX/MEM, stall or not.
  assign o_ex_mem_reg_hz    = ex_alu_q;
  assign o_ex_mem_reg_dst   = ex_dst_q;
  assign o_ex_mem_reg_write = ex_wb_q[WB_REG_WRITE];

  // Memory request fields; everything except the address is gated by the request.
  always_comb begin
    o_dmem_req   = mem_op;
    o_dmem_we    = mem_op & mem_write;
    o_dmem_addr  = {ex_alu_q[NB_BITS-1:2], 2'b00};
    o_dmem_be    = BE_NONE;
    o_dmem_wdata = '0;
    if (mem_op) begin
      o_dmem_be = mem_write ? store_be(size, off) : BE_ALL;
      case (size)
        SIZE_BYTE: o_dmem_wdata = {(NB_BITS/8){ex_rt_q[7:0]}};
        SIZE_HALF: o_dmem_wdata = {(NB_BITS/16){ex_rt_q[15:0]}};
        default:   o_dmem_wdata = ex_rt_q;
      endcase
    end
  end

  mem_load_align #(.NB_BITS(NB_BITS)) u_load_align (
    .i_rdata    (i_dmem_rdata),
    .i_off      (off),
    .i_size     (size),
    .i_unsigned (ex_mem_q[MEM_UNSIGNED]),
    .o_data     (load_data)
  );

  // Misaligned accesses never write the register file.
  always_comb begin
    wb_fwd = ex_wb_q;
    if (misaligned) wb_fwd[WB_REG_WRITE] = 1'b0;
  end

  // FSM next state: WAIT tracks an issued request that has not yet been acked.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_op && !i_dmem_ack) state_d = ST_WAIT;
      ST_WAIT: if (i_dmem_ack || !mem_op) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // EX/MEM register: holds while stalled, loads a bubble when EX has nothing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_valid_q <= 1'b0;
      ex_alu_q   <= '0;
      ex_rt_q    <= '0;
      ex_dst_q   <= '0;
      ex_wb_q    <= '0;
      ex_mem_q   <= '0;
    end else if (!o_stall) begin
      ex_valid_q <= i_valid;
      ex_alu_q   <= i_alu_out;
      ex_rt_q    <= i_data_reg;
      ex_dst_q   <= i_reg_dst;
      ex_wb_q    <= i_valid ? i_wb_ctl  : '0;
      ex_mem_q   <= i_valid ? i_mem_ctl : '0;
    end
  end

  // MEM/WB register: captures on completion, takes a bubble while stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid      <= 1'b0;
      o_alu_out    <= '0;
      o_mem_data   <= '0;
      o_reg_dst    <= '0;
      o_wb_ctl     <= '0;
      o_misaligned <= 1'b0;
    end else if (o_stall) begin
      o_valid      <= 1'b0;
      o_wb_ctl     <= '0;
      o_misaligned <= 1'b0;
    end else begin
      o_valid      <= ex_valid_q;
      o_alu_out    <= ex_alu_q;
      o_mem_data   <= (is_load && mem_op) ? load_data : '0;
      o_reg_dst    <= ex_dst_q;
      o_wb_ctl     <= wb_fwd;
      o_misaligned <= misaligned;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed + randomized bench for mem_access_stage against a behavioural
// model of the memory stage. Honours MEM_ALIGN_CHECK_EN when defined.
module tb_mem_access_stage;

  localparam int NB_BITS = 32;
  localparam int NB_REG  = 5;
  localparam int NB_CTL  = 8;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_valid;
  logic [NB_BITS-1:0] i_alu_out, i_data_reg;
  logic [NB_REG-1:0]  i_reg_dst;
  logic [NB_CTL-1:0]  i_wb_ctl, i_mem_ctl;
  logic               o_stall;
  logic [NB_BITS-1:0] o_ex_mem_reg_hz;
  logic [NB_REG-1:0]  o_ex_mem_reg_dst;
  logic               o_ex_mem_reg_write;
  logic               o_dmem_req, o_dmem_we;
  logic [NB_BITS-1:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]         o_dmem_be;
  logic               i_dmem_ack;
  logic [NB_BITS-1:0] i_dmem_rdata;
  logic               o_valid;
  logic [NB_BITS-1:0] o_alu_out, o_mem_data;
  logic [NB_REG-1:0]  o_reg_dst;
  logic [NB_CTL-1:0]  o_wb_ctl;
  logic               o_misaligned;

  int checks = 0;
  int errors = 0;
  logic [NB_BITS-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  mem_access_stage #(.NB_BITS(NB_BITS), .NB_REG(NB_REG), .NB_CTL(NB_CTL)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_valid            (i_valid),
    .i_alu_out          (i_alu_out),
    .i_data_reg         (i_data_reg),
    .i_reg_dst          (i_reg_dst),
    .i_wb_ctl           (i_wb_ctl),
    .i_mem_ctl          (i_mem_ctl),
    .o_stall            (o_stall),
    .o_ex_mem_reg_hz    (o_ex_mem_reg_hz),
    .o_ex_mem_reg_dst   (o_ex_mem_reg_dst),
    .o_ex_mem_reg_write (o_ex_mem_reg_write),
    .o_dmem_req         (o_dmem_req),
    .o_dmem_we          (o_dmem_we),
    .o_dmem_addr        (o_dmem_addr),
    .o_dmem_wdata       (o_dmem_wdata),
    .o_dmem_be          (o_dmem_be),
    .i_dmem_ack         (i_dmem_ack),
    .i_dmem_rdata       (i_dmem_rdata),
    .o_valid            (o_valid),
    .o_alu_out          (o_alu_out),
    .o_mem_data         (o_mem_data),
    .o_reg_dst          (o_reg_dst),
    .o_wb_ctl           (o_wb_ctl),
    .o_misaligned       (o_misaligned)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},   32'(o_stall), 0);
    check({tag, "_fwd"},     o_ex_mem_reg_hz, 0);
    check({tag, "_fdst"},    32'(o_ex_mem_reg_dst), 0);
    check({tag, "_frw"},     32'(o_ex_mem_reg_write), 0);
    check({tag, "_req"},     32'(o_dmem_req), 0);
    check({tag, "_we"},      32'(o_dmem_we), 0);
    check({tag, "_addr"},    o_dmem_addr, 0);
    check({tag, "_wdata"},   o_dmem_wdata, 0);
    check({tag, "_be"},      32'(o_dmem_be), 0);
    check({tag, "_valid"},   32'(o_valid), 0);
    check({tag, "_alu"},     o_alu_out, 0);
    check({tag, "_mdata"},   o_mem_data, 0);
    check({tag, "_rdst"},    32'(o_reg_dst), 0);
    check({tag, "_wb"},      32'(o_wb_ctl), 0);
    check({tag, "_mis"},     32'(o_misaligned), 0);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic check_bus(input string tag, input logic wr, input logic [31:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
    check({tag, "_req"},  32'(o_dmem_req), 1);
    check({tag, "_we"},   32'(o_dmem_we), 32'(wr));
    check({tag, "_be"},   32'(o_dmem_be), be);
    check({tag, "_addr"}, o_dmem_addr, addr);
    if (wr) check({tag, "_wdata"}, o_dmem_wdata, wdata);
  endtask

  // ---------------- driver ----------------
  // Issues one instruction, answers the memory after k wait cycles, then
  // checks the MEM/WB register against the model.
  task automatic run_instr(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] dst,
                           input logic [7:0] wb, input logic [7:0] mem, input int k,
                           input logic [31:0] rdata);
    logic rd, wr, uns, mis, is_op, is_load;
    logic [1:0] off, sz;
    logic [31:0] exp_be, exp_wdata, exp_addr;
    logic [7:0] exp_wb;
    rd = mem[0]; wr = mem[1]; sz = mem[3:2]; uns = mem[4]; off = alu[1:0];
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if ((rd || wr) && ((sz == 2'd1 && off[0]) || (sz >= 2'd2 && off != 2'd0))) mis = 1'b1;
`endif
    is_op   = (rd || wr) && !mis;
    is_load = rd && !wr;
    exp_addr = alu - 32'(off);
    if (wr) begin
      if (sz == 2'd0)      exp_be = 32'd1 << off;
      else if (sz == 2'd1) exp_be = 32'd3 << (off & 2'd2);
      else                 exp_be = 32'hF;
    end else begin
      exp_be = 32'hF;
    end
    if (sz == 2'd0)      exp_wdata = 32'(rt[7:0]) * 32'h0101_0101;
    else if (sz == 2'd1) exp_wdata = 32'(rt[15:0]) * 32'h0001_0001;
    else                 exp_wdata = rt;
    exp_wb = mis ? (wb & 8'hFE) : wb;
    exp_q.push_back(alu);
    if (is_op && is_load) exp_q.push_back(model_load(rdata, off, sz, uns));

    i_valid = 1'b1; i_alu_out = alu; i_data_reg = rt; i_reg_dst = dst;
    i_wb_ctl = wb; i_mem_ctl = mem;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    check("fwd_alu", o_ex_mem_reg_hz, alu);
    check("fwd_dst", 32'(o_ex_mem_reg_dst), 32'(dst));
    check("fwd_rw",  32'(o_ex_mem_reg_write), 32'(wb[0]));

    if (is_op) begin
      for (int c = 0; c < k; c++) begin
        i_dmem_rdata = $urandom;
        #1;
        check("stall_hi", 32'(o_stall), 1);
        check("stall_bubble", 32'(o_valid), 0);
        check_bus("wait", wr, exp_be, exp_addr, exp_wdata);
        @(posedge i_clk); #1;
        check("fwd_hold", o_ex_mem_reg_hz, alu);
      end
      i_dmem_ack = 1'b1; i_dmem_rdata = rdata;
      #1;
      check("stall_ack", 32'(o_stall), 0);
      check_bus("ack", wr, exp_be, exp_addr, exp_wdata);
      @(posedge i_clk); #1;
      i_dmem_ack = 1'b0; i_dmem_rdata = $urandom;
    end else begin
      // a stray ack here must be ignored
      i_dmem_ack = 1'($urandom_range(0, 1));
      #1;
      check("noop_req", 32'(o_dmem_req), 0);
      check("noop_stall", 32'(o_stall), 0);
      @(posedge i_clk); #1;
      i_dmem_ack = 1'b0;
    end

    check("wb_valid", 32'(o_valid), 1);
    check("wb_alu",   o_alu_out, exp_q.pop_front());
    if (is_op && is_load) check("wb_mdata", o_mem_data, exp_q.pop_front());
    check("wb_dst",   32'(o_reg_dst), 32'(dst));
    check("wb_ctl",   32'(o_wb_ctl), 32'(exp_wb));
    check("wb_mis",   32'(o_misaligned), 32'(mis));
    check("post_req", 32'(o_dmem_req), 0);
  endtask

  task automatic run_bubble();
    i_valid = 1'b0; i_alu_out = $urandom; i_data_reg = $urandom;
    i_wb_ctl = 8'($urandom); i_mem_ctl = 8'($urandom);
    @(posedge i_clk); #1;
    check("bub_req", 32'(o_dmem_req), 0);
    @(posedge i_clk); #1;
    check("bub_valid", 32'(o_valid), 0);
    check("bub_wb", 32'(o_wb_ctl), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] sel, sz;
    logic [2:0] hi;
    logic       uns;
    i_rst = 1'b1; i_valid = 1'b0; i_alu_out = '0; i_data_reg = '0; i_reg_dst = '0;
    i_wb_ctl = '0; i_mem_ctl = '0; i_dmem_ack = 1'b0; i_dmem_rdata = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check_all_zero("rst");
    i_rst = 1'b0;

    // non-memory instruction
    run_instr(32'h37, 32'h0, 5'd3, 8'h01, 8'h00, 0, 32'h0);
    check("alu_lit", o_alu_out, 32'h37);
    // SB to byte 3, ack in the same cycle
    run_instr(32'h103, 32'h0000_00A5, 5'd0, 8'h00, 8'h02, 0, 32'h0);
    // LB / LBU with three wait cycles
    run_instr(32'h102, 32'h0, 5'd4, 8'h03, 8'h01, 3, 32'h12F0_5678);
    check("lb_lit", o_mem_data, 32'hFFFF_FFF0);
    run_instr(32'h102, 32'h0, 5'd4, 8'h03, 8'h11, 3, 32'h12F0_5678);
    check("lbu_lit", o_mem_data, 32'h0000_00F0);
    // LH upper half, LW
    run_instr(32'h202, 32'h0, 5'd5, 8'h03, 8'h05, 1, 32'h8001_1234);
    check("lh_lit", o_mem_data, 32'hFFFF_8001);
    run_instr(32'h200, 32'h0, 5'd6, 8'h03, 8'h09, 2, 32'h8001_1234);
    check("lw_lit", o_mem_data, 32'h8001_1234);
    // SW at a misaligned address, and a read+write conflict (write wins)
    run_instr(32'h102, 32'hDEAD_BEEF, 5'd7, 8'h01, 8'h0A, 1, 32'h0);
    run_instr(32'h301, 32'h0000_1234, 5'd8, 8'h01, 8'h07, 0, 32'h0);
    run_bubble();

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      sel = 2'($urandom_range(0, 3));
      sz  = 2'($urandom_range(0, 2));
      hi  = 3'($urandom_range(0, 7));
      uns = 1'($urandom_range(0, 1));
      run_instr($urandom, $urandom, 5'($urandom), 8'($urandom),
                {hi, uns, sz, sel[1], sel[0]}, $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 7) == 0) run_bubble();
    end

    // reset while waiting for an ack abandons the access
    i_valid = 1'b1; i_alu_out = 32'h400; i_data_reg = 32'h0; i_reg_dst = 5'd9;
    i_wb_ctl = 8'h03; i_mem_ctl = 8'h09;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    check("wr_req", 32'(o_dmem_req), 1);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check_all_zero("rst_wait");
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'hFFFF_FFFF;
    @(posedge i_clk); #1;
    i_dmem_ack = 1'b0;
    check("late_ack_valid", 32'(o_valid), 0);
    check("late_ack_req",   32'(o_dmem_req), 0);
    check("late_ack_data",  o_mem_data, 0);

    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
